reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised multi-port register file with integrated scoreboard for the
//  pipelined datapath. Two combinational read ports, two write ports
//  (WP0 = ALU writeback, WP1 = load writeback), per-register busy bits that
//  track in-flight producers, and a busy-register counter for stall logic.
//  Register 0 is hardwired to zero. Sits between decode (reads/reserve) and
//  writeback.
// PARAMETERS
//  DSIZE  16           data width of every register
//  RSIZE  4            address width
//  NREGS  (1<<RSIZE)   number of registers; must equal 2**RSIZE
// PORTS
//  Clock     in   1           rising-edge clock
//  Reset     in   1           synchronous, active-low
//  RAddr1    in   RSIZE       read port 1 address
//  RAddr2    in   RSIZE       read port 2 address
//  RData1    out  DSIZE       read port 1 data
//  RData2    out  DSIZE       read port 2 data
//  Busy1     out  1           busy bit of RAddr1
//  Busy2     out  1           busy bit of RAddr2
//  Wen0      in   1           write port 0 enable
//  WAddr0    in   RSIZE       write port 0 address
//  WData0    in   DSIZE       write port 0 data
//  Wen1      in   1           write port 1 enable
//  WAddr1    in   RSIZE       write port 1 address
//  WData1    in   DSIZE       write port 1 data
//  Resv      in   1           reserve request: mark ResvAddr busy
//  ResvAddr  in   RSIZE       register being reserved
//  ResvErr   out  1           registered 1-cycle pulse: reserve hit a busy reg
//  BusyCnt   out  RSIZE+1     registered count of set busy bits
// BEHAVIOUR
//  - Reset: Reset sampled low at posedge -> all registers 0, all busy bits
//    0, ResvErr 0, BusyCnt 0. Reset overrides every write/reserve that cycle.
//  - Writes commit at posedge. Writes to addr 0 are dropped. WP0 and WP1
//    targeting the same nonzero address in one cycle: WP0 data is stored.
//  - Reads are combinational from the array; addr 0 -> data 0, busy 0.
//  - Write latency without bypass: data visible on RData the cycle after the
//    write edge.
//  - Scoreboard: Resv=1, ResvAddr!=0 sets busy[ResvAddr] at posedge. Any
//    enabled write to a nonzero address clears that register's busy bit.
//    Reserve and write to the same address in one cycle: busy stays 1
//    (new producer wins); data is still written.
//  - ResvErr: asserted for exactly the cycle after a posedge where Resv=1,
//    ResvAddr!=0, busy[ResvAddr]=1 and no write cleared it that cycle.
//    Reserve is still applied (bit stays 1).
//  - BusyCnt: equals popcount of busy bits after each edge; range
//    0..NREGS-1 (bit 0 never set); no wrap possible.
// CONFIGURATION
//  RF_BYPASS_EN defined: same-cycle write-to-read forwarding. If a read
//    address matches an enabled nonzero write address, RData returns the
//    write data (WP0 over WP1) and Busy for that port reads 0, unless Resv
//    targets the same address in that cycle. Zero-latency writeback.
//  RF_BYPASS_EN undefined: no forwarding; RData/Busy reflect stored state
//    only; decode must stall one extra cycle.
// TESTING
//  1. Reset low 1 cycle after random writes -> all RData 0, Busy 0,
//     BusyCnt 0, ResvErr 0.
//  2. Wen0 WAddr0=0 WData0=16'hFFFF -> RAddr1=0 reads 0; BusyCnt unchanged.
//  3. Wen0 A=5 D=16'h1234 and Wen1 A=5 D=16'hABCD same cycle -> next cycle
//     RData1(5)=16'h1234.
//  4. Resv A=3 -> Busy1(3)=1, BusyCnt=1; Resv A=3 again -> ResvErr pulse 1
//     cycle, BusyCnt=1; Wen1 A=3 -> Busy1=0, BusyCnt=0.
//  5. Resv A=7 with Wen0 A=7 D=16'h0042 same cycle -> Busy(7)=1, data 0x42.
//  6. RF_BYPASS_EN: Wen0 A=9 D=16'h5555, RAddr2=9 same cycle -> RData2=
//     16'h5555, Busy2=0; without macro -> RData2 = old value that cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Multi-port register file with an integrated scoreboard for the pipelined
//   datapath. Two combinational read ports, two write ports (WP0 = ALU
//   writeback, WP1 = load writeback), one busy bit per register tracking an
//   in-flight producer, and a registered count of busy registers for stall
//   logic. Register 0 reads as zero and is never busy.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   : same-cycle write-to-read forwarding (WP0 over WP1); a
//                 forwarded read reports not-busy unless a reserve targets
//                 the same register in that cycle.
//     undefined : reads reflect stored state only.
//
// Ports
//   Clock            rising-edge clock
//   Reset            synchronous, active-low
//   RAddr1/RAddr2    read addresses
//   RData1/RData2    read data (combinational)
//   Busy1/Busy2      busy bit of the addressed register (combinational)
//   Wen0/WAddr0/WData0  write port 0 (ALU writeback, wins on address clash)
//   Wen1/WAddr1/WData1  write port 1 (load writeback)
//   Resv/ResvAddr    reserve request: mark ResvAddr busy at the next edge
//   ResvErr          registered 1-cycle pulse: reserve hit a busy register
//   BusyCnt          registered count of set busy bits
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int NREGS = (1 << RSIZE)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [RSIZE-1:0] RAddr1,
  input  logic [RSIZE-1:0] RAddr2,
  output logic [DSIZE-1:0] RData1,
  output logic [DSIZE-1:0] RData2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic             Wen0,
  input  logic [RSIZE-1:0] WAddr0,
  input  logic [DSIZE-1:0] WData0,
  input  logic             Wen1,
  input  logic [RSIZE-1:0] WAddr1,
  input  logic [DSIZE-1:0] WData1,
  input  logic             Resv,
  input  logic [RSIZE-1:0] ResvAddr,
  output logic             ResvErr,
  output logic [RSIZE:0]   BusyCnt
);

  logic [DSIZE-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wclr;
  logic             resv_hit;
  logic             resv_err_nxt;

  function automatic logic [RSIZE:0] popcount(input logic [NREGS-1:0] v);
    logic [RSIZE:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{RSIZE{1'b0}}, v[i]};
    return c;
  endfunction

  // Scoreboard next state: writes retire producers, then a reserve installs
  // a new one, so a same-cycle reserve and write leave the bit set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wclr = '0;
    if (Wen0 && WAddr0 != '0) wclr[WAddr0] = 1'b1;
    if (Wen1 && WAddr1 != '0) wclr[WAddr1] = 1'b1;

    resv_hit = Resv && (ResvAddr != '0);
    busy_nxt = busy & ~wclr;
    if (resv_hit) busy_nxt[ResvAddr] = 1'b1;
    busy_nxt[0] = 1'b0;

    // Only an error if the producer is still in flight after this edge's writes.
    resv_err_nxt = resv_hit && busy[ResvAddr] && !wclr[ResvAddr];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      // NOTE: the array is reset explicitly because architectural state must
      // read zero after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= '0;
      ResvErr <= 1'b0;
      BusyCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later WP0 update overrides WP1
      // when both target the same register in one cycle.
      if (Wen1 && WAddr1 != '0) regs[WAddr1] <= WData1;
      if (Wen0 && WAddr0 != '0) regs[WAddr0] <= WData0;
      busy    <= busy_nxt;
      ResvErr <= resv_err_nxt;
      BusyCnt <= popcount(busy_nxt);
    end
  end

  // Read ports share one body; index 0 is RAddr1, index 1 is RAddr2.
  logic [1:0][RSIZE-1:0] raddr;
  logic [1:0][DSIZE-1:0] rdata;
  logic [1:0]            rbusy;

  assign raddr = {RAddr2, RAddr1};

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < 2; p++) begin
      if (raddr[p] != '0) begin
        rdata[p] = regs[raddr[p]];
        rbusy[p] = busy[raddr[p]];
`ifdef RF_BYPASS_EN
        // Forwarded data is final unless a new producer claims the register now.
        if (Wen0 && WAddr0 == raddr[p]) begin
          rdata[p] = WData0;
          rbusy[p] = resv_hit && (ResvAddr == raddr[p]);
        end else if (Wen1 && WAddr1 == raddr[p]) begin
          rdata[p] = WData1;
          rbusy[p] = resv_hit && (ResvAddr == raddr[p]);
        end
`endif
      end
    end
  end

  assign RData1 = rdata[0];
  assign RData2 = rdata[1];
  assign Busy1  = rbusy[0];
  assign Busy2  = rbusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//   Self-checking bench for reg_file_sb. A behavioural model (plain arrays of
//   register values and busy flags) is advanced at every rising edge; one
//   compare process checks every DUT output against it on each falling edge.
//   Directed scenarios add literal expectations that pin the model itself,
//   followed by a long randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int DSIZE = 16;
  localparam int RSIZE = 4;
  localparam int NREGS = 1 << RSIZE;

  logic             Clock;
  logic             Reset;
  logic [RSIZE-1:0] RAddr1, RAddr2;
  logic [DSIZE-1:0] RData1, RData2;
  logic             Busy1, Busy2;
  logic             Wen0, Wen1;
  logic [RSIZE-1:0] WAddr0, WAddr1;
  logic [DSIZE-1:0] WData0, WData1;
  logic             Resv;
  logic [RSIZE-1:0] ResvAddr;
  logic             ResvErr;
  logic [RSIZE:0]   BusyCnt;

  reg_file_sb #(.DSIZE(DSIZE), .RSIZE(RSIZE), .NREGS(NREGS)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .RAddr1   (RAddr1),
    .RAddr2   (RAddr2),
    .RData1   (RData1),
    .RData2   (RData2),
    .Busy1    (Busy1),
    .Busy2    (Busy2),
    .Wen0     (Wen0),
    .WAddr0   (WAddr0),
    .WData0   (WData0),
    .Wen1     (Wen1),
    .WAddr1   (WAddr1),
    .WData1   (WData1),
    .Resv     (Resv),
    .ResvAddr (ResvAddr),
    .ResvErr  (ResvErr),
    .BusyCnt  (BusyCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DSIZE-1:0] m_regs [NREGS];
  bit               m_busy [NREGS];
  bit               m_err;
  int               m_cnt;
  bit               cmp_en = 1'b0;

  // Applies one clock edge of architectural rules to the model state.
  task automatic model_edge();
    bit wrote_resv;
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      wrote_resv = (Wen0 && WAddr0 == ResvAddr) || (Wen1 && WAddr1 == ResvAddr);
      m_err = Resv && ResvAddr != 0 && m_busy[ResvAddr] && !wrote_resv;
      if (Wen1 && WAddr1 != 0) begin
        m_regs[WAddr1] = WData1;
        m_busy[WAddr1] = 1'b0;
      end
      if (Wen0 && WAddr0 != 0) begin
        m_regs[WAddr0] = WData0;
        m_busy[WAddr0] = 1'b0;
      end
      if (Resv && ResvAddr != 0) m_busy[ResvAddr] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < NREGS; i++) if (m_busy[i]) m_cnt++;
  endtask

  // Expected combinational read for a given address under current inputs.
  task automatic model_read(input logic [RSIZE-1:0] a, output logic [DSIZE-1:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (a != 0) begin
      d = m_regs[a];
      b = m_busy[a];
`ifdef RF_BYPASS_EN
      if (Wen0 && WAddr0 == a) begin
        d = WData0;
        b = Resv && ResvAddr == a;
      end else if (Wen1 && WAddr1 == a) begin
        d = WData1;
        b = Resv && ResvAddr == a;
      end
`endif
    end
  endtask

  // Single compare process: every falling edge once the model is valid.
  always @(negedge Clock) begin
    logic [DSIZE-1:0] ed;
    bit               eb;
    if (cmp_en) begin
      model_read(RAddr1, ed, eb);
      check("rdata1", 32'(RData1), 32'(ed));
      check("busy1",  32'(Busy1),  32'(eb));
      model_read(RAddr2, ed, eb);
      check("rdata2", 32'(RData2), 32'(ed));
      check("busy2",  32'(Busy2),  32'(eb));
      check("resv_err", 32'(ResvErr), 32'(m_err));
      check("busy_cnt", 32'(BusyCnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    Wen0 = 1'b0; WAddr0 = '0; WData0 = '0;
    Wen1 = 1'b0; WAddr1 = '0; WData1 = '0;
    Resv = 1'b0; ResvAddr = '0;
  endtask

  task automatic rand_inputs();
    RAddr1   = RSIZE'($urandom_range(NREGS-1));
    RAddr2   = RSIZE'($urandom_range(NREGS-1));
    Wen0     = ($urandom_range(1) == 1);
    WAddr0   = RSIZE'($urandom_range(NREGS-1));
    WData0   = DSIZE'($urandom);
    Wen1     = ($urandom_range(1) == 1);
    WAddr1   = RSIZE'($urandom_range(NREGS-1));
    WData1   = DSIZE'($urandom);
    Resv     = ($urandom_range(9) < 4);
    ResvAddr = RSIZE'($urandom_range(NREGS-1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    RAddr1 = '0; RAddr2 = '0;
    idle();
    tick();
    tick();
    cmp_en = 1'b1;
    Reset  = 1'b1;

    // 1. Random traffic, then one reset cycle that must override it.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
    end
    rand_inputs();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    idle();
    for (int a = 0; a < NREGS; a += 5) begin
      RAddr1 = RSIZE'(a);
      RAddr2 = RSIZE'(a + 1);
      #1;
      check("rst_rdata1", 32'(RData1), 32'h0);
      check("rst_rdata2", 32'(RData2), 32'h0);
      check("rst_busy1",  32'(Busy1),  32'h0);
    end
    check("rst_busy_cnt", 32'(BusyCnt), 32'h0);
    check("rst_resv_err", 32'(ResvErr), 32'h0);

    // 2. Write to register 0 is dropped and does not touch BusyCnt.
    Resv = 1'b1; ResvAddr = 4'd2;
    tick();
    idle();
    Wen0 = 1'b1; WAddr0 = 4'd0; WData0 = 16'hFFFF;
    tick();
    idle();
    RAddr1 = 4'd0;
    #1;
    check("r0_rdata", 32'(RData1), 32'h0);
    check("r0_busy_cnt", 32'(BusyCnt), 32'd1);
    Wen1 = 1'b1; WAddr1 = 4'd2; WData1 = 16'h0002;
    tick();
    idle();

    // 3. WP0 and WP1 clash on one address: WP0 data is stored.
    Wen0 = 1'b1; WAddr0 = 4'd5; WData0 = 16'h1234;
    Wen1 = 1'b1; WAddr1 = 4'd5; WData1 = 16'hABCD;
    tick();
    idle();
    RAddr1 = 4'd5;
    #1;
    check("clash_rdata", 32'(RData1), 32'h1234);

    // 4. Reserve, double reserve (error pulse), then writeback clears.
    Resv = 1'b1; ResvAddr = 4'd3;
    tick();
    idle();
    RAddr1 = 4'd3;
    #1;
    check("resv_busy1", 32'(Busy1), 32'h1);
    check("resv_cnt", 32'(BusyCnt), 32'd1);
    check("resv_no_err", 32'(ResvErr), 32'h0);
    Resv = 1'b1; ResvAddr = 4'd3;
    tick();
    idle();
    #1;
    check("dbl_resv_err", 32'(ResvErr), 32'h1);
    check("dbl_resv_cnt", 32'(BusyCnt), 32'd1);
    tick();
    check("err_one_cycle", 32'(ResvErr), 32'h0);
    Wen1 = 1'b1; WAddr1 = 4'd3; WData1 = 16'h0033;
    tick();
    idle();
    #1;
    check("clr_busy1", 32'(Busy1), 32'h0);
    check("clr_cnt", 32'(BusyCnt), 32'd0);

    // 5. Reserve and write same register same cycle: busy stays, data lands.
    Resv = 1'b1; ResvAddr = 4'd7;
    Wen0 = 1'b1; WAddr0 = 4'd7; WData0 = 16'h0042;
    tick();
    idle();
    RAddr1 = 4'd7;
    #1;
    check("rw_busy1", 32'(Busy1), 32'h1);
    check("rw_rdata", 32'(RData1), 32'h0042);
    check("rw_cnt", 32'(BusyCnt), 32'd1);

    // 6. Same-cycle read of a register being written.
    Wen0 = 1'b1; WAddr0 = 4'd9; WData0 = 16'h1111;
    tick();
    idle();
    Wen0 = 1'b1; WAddr0 = 4'd9; WData0 = 16'h5555;
    RAddr2 = 4'd9;
    #1;
`ifdef RF_BYPASS_EN
    check("byp_rdata2", 32'(RData2), 32'h5555);
`else
    check("byp_rdata2", 32'(RData2), 32'h1111);
`endif
    check("byp_busy2", 32'(Busy2), 32'h0);
    tick();
    idle();
    #1;
    check("after_wr_rdata2", 32'(RData2), 32'h5555);

    // Randomized phase with rare resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      Reset = ($urandom_range(199) != 0);
      tick();
    end
    Reset = 1'b1;
    idle();
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
